// File: rtl/space_shooter_pkg.sv
// Shared types and widths for the space shooter game logic.
// Health is 4 bits wide; frame counters are 8 bits wide.
package space_shooter_pkg;

    localparam int HEALTH_W    = 4;
    localparam int FRAME_CNT_W = 8;

    localparam logic [1:0] ST_ALIVE = 2'd0;
    localparam logic [1:0] ST_HIT   = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;

    typedef enum logic [1:0] {
        STATE_ALIVE = ST_ALIVE,
        STATE_HIT   = ST_HIT,
        STATE_DEAD  = ST_DEAD
    } state_t;

    // Sums are formed one bit wider than health so that they cannot wrap
    // before the ceiling is applied.
    function automatic logic [HEALTH_W-1:0] clamp_health(
        input logic [HEALTH_W:0]   value,
        input logic [HEALTH_W-1:0] ceiling
    );
        return (value > {1'b0, ceiling}) ? ceiling : value[HEALTH_W-1:0];
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame counter that advances on frame ticks and wraps to zero after 'last'.
// 'terminal' is high in the advancing cycle in which the count equals 'last'.
module frame_timer
    import space_shooter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [FRAME_CNT_W-1:0] last,
    output logic [FRAME_CNT_W-1:0] count,
    output logic                   terminal
);

    assign terminal = advance && (count == last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || terminal) begin
            count <= '0;
        end else if (advance) begin
            count <= count + FRAME_CNT_W'(1);
        end
    end

endmodule

// File: rtl/health_controller.sv
// Player health state machine: damage, heal, a post-hit flash/invulnerability
// window, optional per-frame regeneration and a dead/restart sequence.
module health_controller
    import space_shooter_pkg::*;
#(
    parameter int MAX_HEALTH       = 15,
    parameter int HIT_FLASH_FRAMES = 8,
    parameter int INVULN_FRAMES    = 30,
    parameter int REGEN_FRAMES     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                damage_req,
    input  logic [HEALTH_W-1:0] damage_amt,
    input  logic                heal_req,
    input  logic [HEALTH_W-1:0] heal_amt,
    input  logic                restart,
    output logic [HEALTH_W-1:0] health,
    output logic                hit,
    output logic                invulnerable,
    output logic                dead
);

    localparam logic [HEALTH_W-1:0]    MAX_H      = HEALTH_W'(MAX_HEALTH);
    localparam logic [FRAME_CNT_W-1:0] INV_LAST   = FRAME_CNT_W'(INVULN_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] REGEN_LAST =
        (REGEN_FRAMES == 0) ? '0 : FRAME_CNT_W'(REGEN_FRAMES - 1);
    localparam logic [FRAME_CNT_W:0]   FLASH_LIM  = (FRAME_CNT_W + 1)'(HIT_FLASH_FRAMES);

    state_t                 state;
    state_t                 state_next;
    logic [HEALTH_W-1:0]    health_next;
    logic                   hit_next;
    logic [HEALTH_W:0]      heal_sum;
    logic [FRAME_CNT_W:0]   inv_cnt_next;

    logic [FRAME_CNT_W-1:0] inv_cnt;
    logic [FRAME_CNT_W-1:0] regen_cnt_unused;
    logic                   inv_term;
    logic                   regen_term;

    logic damage_ok;
    logic heal_ok;
    logic regen_inc;

    // Accepted-event qualifiers, in priority order restart > damage > heal > tick.
    assign damage_ok = !restart && (state == STATE_ALIVE) && damage_req && (damage_amt != '0);
    assign heal_ok   = !restart && !damage_ok && heal_req && (state != STATE_DEAD);
    assign regen_inc = !restart && !damage_ok && regen_term;

    frame_timer u_inv_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (restart || (state != STATE_HIT)),
        .advance  (frame_tick && (state == STATE_HIT)),
        .last     (INV_LAST),
        .count    (inv_cnt),
        .terminal (inv_term)
    );

    // Regen progress is held at zero outside ALIVE and discarded by a hit.
    frame_timer u_regen_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (restart || damage_ok || (state != STATE_ALIVE)),
        .advance  ((REGEN_FRAMES != 0) && frame_tick && (state == STATE_ALIVE)),
        .last     (REGEN_LAST),
        .count    (regen_cnt_unused),
        .terminal (regen_term)
    );

    always_comb begin
        state_next   = state;
        health_next  = health;
        heal_sum     = {1'b0, health}
                     + (heal_ok ? {1'b0, heal_amt} : '0)
                     + {{HEALTH_W{1'b0}}, regen_inc};
        if (restart) begin
            state_next  = STATE_ALIVE;
            health_next = MAX_H;
        end else if (damage_ok) begin
            if (damage_amt >= health) begin
                state_next  = STATE_DEAD;
                health_next = '0;
            end else begin
                state_next  = STATE_HIT;
                health_next = health - damage_amt;
            end
        end else begin
            // In DEAD no heal or regen is qualified, so the sum stays at zero.
            health_next = clamp_health(heal_sum, MAX_H);
            if ((state == STATE_HIT) && inv_term) begin
                state_next = STATE_ALIVE;
            end
        end

        // Window position the HIT state will hold after this edge; a fresh hit starts at 0.
        inv_cnt_next = '0;
        if ((state == STATE_HIT) && (state_next == STATE_HIT)) begin
            inv_cnt_next = {1'b0, inv_cnt} + {{FRAME_CNT_W{1'b0}}, frame_tick};
        end
        hit_next = (state_next == STATE_HIT) && (inv_cnt_next < FLASH_LIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= STATE_ALIVE;
            health       <= MAX_H;
            hit          <= 1'b0;
            invulnerable <= 1'b0;
            dead         <= 1'b0;
        end else begin
            state        <= state_next;
            health       <= health_next;
            hit          <= hit_next;
            invulnerable <= (state_next == STATE_HIT);
            dead         <= (state_next == STATE_DEAD);
        end
    end

endmodule

// File: tb/tb_health_controller.sv
// Bench for health_controller: a no-regen and a REGEN_FRAMES=4 instance share
// stimulus and are scored against a frame-counting model plus fixed vectors.
module tb_health_controller;

    localparam int MAXH  = 15;
    localparam int FLASH = 8;
    localparam int INV   = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       damage_req = 1'b0;
    logic [3:0] damage_amt = 4'd0;
    logic       heal_req = 1'b0;
    logic [3:0] heal_amt = 4'd0;
    logic       restart = 1'b0;

    logic [3:0] health_o [2];
    logic       hit_o    [2];
    logic       inv_o    [2];
    logic       dead_o   [2];

    always #5 clk = ~clk;

    health_controller dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .damage_req   (damage_req),
        .damage_amt   (damage_amt),
        .heal_req     (heal_req),
        .heal_amt     (heal_amt),
        .restart      (restart),
        .health       (health_o[0]),
        .hit          (hit_o[0]),
        .invulnerable (inv_o[0]),
        .dead         (dead_o[0])
    );

    health_controller #(.REGEN_FRAMES(4)) dut_regen (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .damage_req   (damage_req),
        .damage_amt   (damage_amt),
        .heal_req     (heal_req),
        .heal_amt     (heal_amt),
        .restart      (restart),
        .health       (health_o[1]),
        .hit          (hit_o[1]),
        .invulnerable (inv_o[1]),
        .dead         (dead_o[1])
    );

    typedef enum int {M_ALIVE, M_HIT, M_DEAD} mode_t;
    typedef struct {
        mode_t mode;
        int    h;
        int    frames_hit;
        int    frames_regen;
    } model_t;

    typedef struct {
        logic       t;
        logic       dr;
        logic [3:0] da;
        logic       hr;
        logic [3:0] ha;
        logic       rs;
        logic [3:0] eh;
        logic       ehit;
        logic       einv;
        logic       edead;
    } vec_t;

    int        regen_cfg [2] = '{0, 4};
    model_t    mdl [2];
    logic [6:0] exp_q [$];
    vec_t      vt [15];
    int        n_checks = 0;
    int        n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input int idx, input string tag, input int eh,
                              input int ehit, input int einv, input int edead);
        check($sformatf("%s.dut%0d.health", tag, idx), int'(health_o[idx]), eh);
        check($sformatf("%s.dut%0d.hit", tag, idx), int'(hit_o[idx]), ehit);
        check($sformatf("%s.dut%0d.invulnerable", tag, idx), int'(inv_o[idx]), einv);
        check($sformatf("%s.dut%0d.dead", tag, idx), int'(dead_o[idx]), edead);
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.mode = M_ALIVE;
        m.h = MAXH;
        m.frames_hit = 0;
        m.frames_regen = 0;
        return m;
    endfunction

    // One clock of game rules, counting elapsed frames since the last hit / last regen.
    function automatic model_t model_next(model_t s, int regen, logic t, logic dr,
                                          logic [3:0] da, logic hr, logic [3:0] ha,
                                          logic rs);
        model_t n = s;
        int gain = 0;
        if (rs) return model_reset();
        if (s.mode == M_ALIVE && dr && da != 4'd0) begin
            n.h = (s.h > int'(da)) ? s.h - int'(da) : 0;
            n.mode = (n.h == 0) ? M_DEAD : M_HIT;
            n.frames_hit = 0;
            n.frames_regen = 0;
            return n;
        end
        if (hr && s.mode != M_DEAD) gain += int'(ha);
        if (s.mode == M_ALIVE && regen != 0 && t) begin
            n.frames_regen++;
            if (n.frames_regen == regen) begin
                n.frames_regen = 0;
                gain++;
            end
        end
        n.h = (s.h + gain > MAXH) ? MAXH : s.h + gain;
        if (s.mode == M_HIT && t) begin
            n.frames_hit++;
            if (n.frames_hit == INV) begin
                n.mode = M_ALIVE;
                n.frames_hit = 0;
            end
        end
        return n;
    endfunction

    // Drive one clock of inputs, advance the models, then score both DUTs.
    task automatic cyc(input logic t, input logic dr, input logic [3:0] da,
                       input logic hr, input logic [3:0] ha, input logic rs);
        logic [6:0] e;
        frame_tick = t;
        damage_req = dr;
        damage_amt = da;
        heal_req   = hr;
        heal_amt   = ha;
        restart    = rs;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            mdl[i] = model_next(mdl[i], regen_cfg[i], t, dr, da, hr, ha, rs);
            exp_q.push_back({4'(mdl[i].h),
                             (mdl[i].mode == M_HIT) && (mdl[i].frames_hit < FLASH),
                             mdl[i].mode == M_HIT,
                             mdl[i].mode == M_DEAD});
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            expect_out(i, "model", int'(e[6:3]), int'(e[2]), int'(e[1]), int'(e[0]));
        end
        frame_tick = 1'b0;
        damage_req = 1'b0;
        damage_amt = 4'd0;
        heal_req   = 1'b0;
        heal_amt   = 4'd0;
        restart    = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic do_restart();
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    endtask

    task automatic damage(input logic [3:0] amt);
        cyc(1'b0, 1'b1, amt, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic tick_frame(input logic dr, input logic [3:0] da);
        cyc(1'b1, dr, da, 1'b0, 4'd0, 1'b0);
        idle();
    endtask

    function automatic vec_t mk(input logic t, input logic dr, input logic [3:0] da,
                                input logic hr, input logic [3:0] ha, input logic rs,
                                input logic [3:0] eh, input logic ehit,
                                input logic einv, input logic edead);
        vec_t v;
        v.t = t; v.dr = dr; v.da = da; v.hr = hr; v.ha = ha; v.rs = rs;
        v.eh = eh; v.ehit = ehit; v.einv = einv; v.edead = edead;
        return v;
    endfunction

    initial begin
        //        tick  dmg   amt    heal  amt    rst   health hit   inv   dead
        vt[0]  = mk(1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
        vt[1]  = mk(1'b0, 1'b1, 4'd4,  1'b0, 4'd0,  1'b0, 4'd11, 1'b1, 1'b1, 1'b0);
        vt[2]  = mk(1'b0, 1'b1, 4'd3,  1'b0, 4'd0,  1'b0, 4'd11, 1'b1, 1'b1, 1'b0);
        vt[3]  = mk(1'b0, 1'b0, 4'd0,  1'b1, 4'd2,  1'b0, 4'd13, 1'b1, 1'b1, 1'b0);
        vt[4]  = mk(1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 4'd13, 1'b1, 1'b1, 1'b0);
        vt[5]  = mk(1'b0, 1'b1, 4'd5,  1'b0, 4'd0,  1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        vt[6]  = mk(1'b0, 1'b1, 4'd0,  1'b0, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
        vt[7]  = mk(1'b0, 1'b1, 4'd15, 1'b1, 4'd15, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1);
        vt[8]  = mk(1'b0, 1'b0, 4'd0,  1'b1, 4'd4,  1'b0, 4'd0,  1'b0, 1'b0, 1'b1);
        vt[9]  = mk(1'b1, 1'b1, 4'd1,  1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b1);
        vt[10] = mk(1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        vt[11] = mk(1'b0, 1'b1, 4'd2,  1'b1, 4'd5,  1'b0, 4'd13, 1'b1, 1'b1, 1'b0);
        vt[12] = mk(1'b0, 1'b0, 4'd0,  1'b1, 4'd9,  1'b0, 4'd15, 1'b1, 1'b1, 1'b0);
        vt[13] = mk(1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        vt[14] = mk(1'b0, 1'b0, 4'd0,  1'b1, 4'd15, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);

        // Reset and idle frames.
        for (int i = 0; i < 2; i++) mdl[i] = model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) expect_out(i, "reset", 15, 0, 0, 0);
        rst = 1'b0;
        repeat (5) tick_frame(1'b0, 4'd0);
        for (int i = 0; i < 2; i++) expect_out(i, "idle5", 15, 0, 0, 0);

        // Fixed single-cycle vectors.
        for (int k = 0; k < 15; k++) begin
            cyc(vt[k].t, vt[k].dr, vt[k].da, vt[k].hr, vt[k].ha, vt[k].rs);
            for (int i = 0; i < 2; i++)
                expect_out(i, $sformatf("vec%0d", k), int'(vt[k].eh), int'(vt[k].ehit),
                           int'(vt[k].einv), int'(vt[k].edead));
        end

        // Flash and invulnerability window; damage mid-window and on the closing tick.
        do_restart();
        damage(4'd4);
        expect_out(0, "win_start", 11, 1, 1, 0);
        for (int k = 1; k <= INV; k++) begin
            tick_frame((k == 10) || (k == INV), 4'd3);
            expect_out(0, $sformatf("win_f%0d", k), 11, (k < FLASH) ? 1 : 0,
                       (k < INV) ? 1 : 0, 0);
        end
        damage(4'd3);
        for (int i = 0; i < 2; i++) expect_out(i, "after_win", 8, 1, 1, 0);

        // Death, heal ignored while dead, restart.
        do_restart();
        damage(4'd13);
        expect_out(0, "to_2", 2, 1, 1, 0);
        repeat (INV) tick_frame(1'b0, 4'd0);
        damage(4'd5);
        expect_out(0, "kill", 0, 0, 0, 1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0);
        expect_out(0, "dead_heal", 0, 0, 0, 1);
        do_restart();
        expect_out(0, "revive", 15, 0, 0, 0);

        // Regeneration on the REGEN_FRAMES=4 instance.
        do_restart();
        damage(4'd5);
        repeat (INV) tick_frame(1'b0, 4'd0);
        expect_out(1, "regen_base", 10, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            tick_frame(1'b0, 4'd0);
            if (k == 4) expect_out(1, "regen_4", 11, 0, 0, 0);
            if (k == 8) expect_out(1, "regen_8", 12, 0, 0, 0);
        end
        repeat (2) tick_frame(1'b0, 4'd0);
        damage(4'd1);
        expect_out(1, "regen_hit", 11, 1, 1, 0);
        repeat (INV) tick_frame(1'b0, 4'd0);
        repeat (3) tick_frame(1'b0, 4'd0);
        expect_out(1, "regen_restart3", 11, 0, 0, 0);
        tick_frame(1'b0, 4'd0);
        expect_out(1, "regen_restart4", 12, 0, 0, 0);
        repeat (60) tick_frame(1'b0, 4'd0);
        expect_out(1, "regen_cap", 15, 0, 0, 0);

        // Asynchronous reset in the middle of a hit window.
        do_restart();
        damage(4'd4);
        repeat (3) tick_frame(1'b0, 4'd0);
        rst = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) expect_out(i, "async_rst", 15, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) mdl[i] = model_reset();
        damage(4'd4);
        repeat (INV + 2) tick_frame(1'b0, 4'd0);

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            cyc($urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0,
                4'($urandom_range(0, 6)),
                $urandom_range(0, 9) == 0,
                4'($urandom_range(0, 15)),
                $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
